step_counter: RTL and testbench

Synchronous event counter for the LED snake datapath. Samples an asynchronous input level `in`, detects its rising edges in the `clk` domain and counts them modulo `CNT_MAX`. It raises a one-cycle `ovf` pulse on every wrap. Downstream logic uses `cnt` as a step or position index and `ovf` as a "lap complete" tick.

---
 rtl/step_counter.sv | 55 +++++
 tb/tb_step_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// Rising-edge event counter: synchronizes an asynchronous level, counts its
// low-to-high transitions modulo CNT_MAX and pulses ovf once per wrap.
module step_counter #(
    parameter int unsigned CNT_MAX     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [4:0] cnt,
    output logic       ovf
);

    localparam logic [4:0] CNT_LAST = 5'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [4:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   rise;

    // sync_q[0] is the first flop after the pad; the top bit is the safe copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            prev_q <= sync_q[SYNC_STAGES-1];
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (rise) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: three instances (modulus 8, 1, 31) share
// clock, reset and the event input.
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [4:0] cnt8, cnt1, cnt31;
    logic       ovf8, ovf1, ovf31;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    step_counter #(.CNT_MAX(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in(din), .cnt(cnt8), .ovf(ovf8)
    );
    step_counter #(.CNT_MAX(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .in(din), .cnt(cnt1), .ovf(ovf1)
    );
    step_counter #(.CNT_MAX(31), .SYNC_STAGES(2)) dut31 (
        .clk(clk), .rst(rst), .in(din), .cnt(cnt31), .ovf(ovf31)
    );

    typedef struct {
        logic       in_v;
        logic [4:0] c8;
        logic       o8;
        logic       o1;
        logic [4:0] c31;
    } vec_t;

    vec_t tbl[18];

    // Pulse monitor for the long run
    logic mon_en = 1'b0;
    logic ovf8_prev = 1'b0;
    int   n8_cycles = 0, n8_edges = 0, n1_cycles = 0, n31_cycles = 0;
    int   max31 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ovf8) n8_cycles++;
            if (ovf8 && !ovf8_prev) n8_edges++;
            if (ovf1) n1_cycles++;
            if (ovf31) n31_cycles++;
            if (int'(cnt31) > max31) max31 = int'(cnt31);
        end
        ovf8_prev = ovf8;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic event_pulse();
        din = 1'b1;
        repeat (3) step();
        din = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd1, 1'b0, 1'b1, 5'd1};
        tbl[1]  = '{1'b0, 5'd1, 1'b0, 1'b0, 5'd1};
        tbl[2]  = '{1'b1, 5'd2, 1'b0, 1'b1, 5'd2};
        tbl[3]  = '{1'b0, 5'd2, 1'b0, 1'b0, 5'd2};
        tbl[4]  = '{1'b1, 5'd3, 1'b0, 1'b1, 5'd3};
        tbl[5]  = '{1'b0, 5'd3, 1'b0, 1'b0, 5'd3};
        tbl[6]  = '{1'b1, 5'd4, 1'b0, 1'b1, 5'd4};
        tbl[7]  = '{1'b0, 5'd4, 1'b0, 1'b0, 5'd4};
        tbl[8]  = '{1'b1, 5'd5, 1'b0, 1'b1, 5'd5};
        tbl[9]  = '{1'b0, 5'd5, 1'b0, 1'b0, 5'd5};
        tbl[10] = '{1'b1, 5'd6, 1'b0, 1'b1, 5'd6};
        tbl[11] = '{1'b0, 5'd6, 1'b0, 1'b0, 5'd6};
        tbl[12] = '{1'b1, 5'd7, 1'b0, 1'b1, 5'd7};
        tbl[13] = '{1'b0, 5'd7, 1'b0, 1'b0, 5'd7};
        tbl[14] = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd8};
        tbl[15] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd8};
        tbl[16] = '{1'b1, 5'd1, 1'b0, 1'b1, 5'd9};
        tbl[17] = '{1'b0, 5'd1, 1'b0, 1'b0, 5'd9};

        // Reset hold with in toggling
        rst = 1'b1;
        din = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            din = ~din;
            step();
            check("rst_hold_cnt", cnt8, 0);
            check("rst_hold_ovf", ovf8, 0);
        end
        din = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_cnt", cnt8, 0);
        check("post_rst_ovf", ovf8, 0);

        // Count and first wrap: each row holds its level for 3 cycles
        for (int unsigned i = 0; i < 18; i++) begin
            din = tbl[i].in_v;
            repeat (3) step();
            check($sformatf("tbl%0d_cnt8", i), cnt8, tbl[i].c8);
            check($sformatf("tbl%0d_ovf8", i), ovf8, tbl[i].o8);
            check($sformatf("tbl%0d_cnt1", i), cnt1, 0);
            check($sformatf("tbl%0d_ovf1", i), ovf1, tbl[i].o1);
            check($sformatf("tbl%0d_cnt31", i), cnt31, tbl[i].c31);
        end

        // 40 more events: dut8 1->1 wraps 5 times, dut31 9->49 wraps once
        mon_en = 1'b1;
        for (int unsigned i = 0; i < 40; i++) event_pulse();
        mon_en = 1'b0;
        check("run40_ovf8_cycles", n8_cycles, 5);
        check("run40_ovf8_pulses", n8_edges, 5);
        check("run40_ovf1_cycles", n1_cycles, 40);
        check("run40_ovf31_cycles", n31_cycles, 1);
        check("run40_cnt31_max", max31, 30);
        check("run40_cnt8_end", cnt8, 1);
        check("run40_cnt31_end", cnt31, 18);

        // Asynchronous reset mid-count
        repeat (4) event_pulse();
        check("mid_cnt8_pre", cnt8, 5);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_cnt8", cnt8, 0);
        check("mid_rst_ovf8", ovf8, 0);
        check("mid_rst_cnt31", cnt31, 0);
        #1;
        rst = 1'b0;
        step();
        event_pulse();
        check("mid_resume_cnt8", cnt8, 1);

        // Level high across reset release, with exact latency
        rst = 1'b1;
        din = 1'b1;
        repeat (2) step();
        check("lvl_in_rst_cnt8", cnt8, 0);
        rst = 1'b0;
        step();
        check("lvl_e0_cnt8", cnt8, 0);
        step();
        check("lvl_e1_cnt8", cnt8, 0);
        check("lvl_e1_ovf1", ovf1, 0);
        step();
        check("lvl_e2_cnt8", cnt8, 1);
        check("lvl_e2_ovf1", ovf1, 1);
        step();
        check("lvl_e3_ovf1", ovf1, 0);
        repeat (5) step();
        check("lvl_hold_cnt8", cnt8, 1);
        din = 1'b0;
        repeat (3) step();
        check("lvl_fall_cnt8", cnt8, 1);
        event_pulse();
        check("lvl_next_cnt8", cnt8, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
